// File: rtl/beam_buf_pkg.sv
// Shared definitions for the beam buffer write/read scheduler.
// Holds the read FSM state encoding and the default geometry of the
// four-bank buffer so the top and the bench agree on one set of numbers.
package beam_buf_pkg;

  localparam int DEF_NUM_BANKS    = 4;
  localparam int DEF_BLK_LEN      = 64;
  localparam int DEF_READ_LATENCY = 3;

  typedef enum logic [0:0] {
    RD_IDLE = 1'b0,
    RD_RUN  = 1'b1
  } rd_state_t;

endpackage

// File: rtl/beam_buf_dly.sv
// Fixed-depth synchronous delay line used to align read framing with the
// bank RAM read latency.
//   i_clk   : clock
//   i_reset : synchronous active-high reset, clears every stage
//   i_d     : WIDTH-bit input sampled every cycle
//   o_q     : i_d delayed by exactly DEPTH cycles
module beam_buf_dly
  import beam_buf_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int DEPTH = DEF_READ_LATENCY
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] stage [DEPTH];

  // The line shifts every cycle regardless of downstream state, so a stall
  // upstream shows up as a hole in the delayed stream rather than a hold.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= i_d;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign o_q = stage[DEPTH-1];

endmodule

// File: rtl/beam_buf_sched.sv
// Write/read scheduler for the banked, ping-ponged beam buffer.
// Incoming blocks are dealt round-robin across the banks; each bank holds two
// pages selected by the address MSB. When every bank of a page holds a block,
// one aligned sweep reads that page from all banks in parallel.
//   i_clk, i_reset          : clock, synchronous active-high reset
//   i_wr_vld, i_wr_last     : upstream word strobe and end-of-block marker
//   o_wr_wen, o_wr_addr     : registered one-hot bank enable and {page, index}
//   i_rd_ready              : downstream can take a read this cycle
//   o_rd_en, o_rd_addr      : read strobe to all banks and {rd_page, rd_cnt}
//   o_rd_dvld/sop/eop       : framing delayed by READ_LATENCY to meet bank data
//   o_page_full             : per-page full flags
//   o_err_len               : one-cycle pulse on a short or long block
//   o_overflow              : sticky, a word arrived while its page was full
//   o_dbg_rd_state          : current read FSM state
//
// Handshake: a read is issued in exactly those cycles where the FSM is in
// RD_RUN and i_rd_ready is high (o_rd_en = RD_RUN & i_rd_ready); the read
// address is stable while i_rd_ready is low. The write side has no back
// pressure: i_wr_vld words are taken unless the target page is full, in which
// case they are dropped and o_overflow records it.
module beam_buf_sched
  import beam_buf_pkg::*;
#(
  parameter int NUM_BANKS    = DEF_NUM_BANKS,
  parameter int BLK_LEN      = DEF_BLK_LEN,
  parameter int ADDR_WIDTH   = 7,
  parameter int READ_LATENCY = DEF_READ_LATENCY
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_wr_vld,
  input  logic                  i_wr_last,
  output logic [NUM_BANKS-1:0]  o_wr_wen,
  output logic [ADDR_WIDTH-1:0] o_wr_addr,
  input  logic                  i_rd_ready,
  output logic                  o_rd_en,
  output logic [ADDR_WIDTH-1:0] o_rd_addr,
  output logic                  o_rd_dvld,
  output logic                  o_rd_sop,
  output logic                  o_rd_eop,
  output logic [1:0]            o_page_full,
  output logic                  o_err_len,
  output logic                  o_overflow,
  output rd_state_t             o_dbg_rd_state
);

  localparam int CNT_W  = ADDR_WIDTH - 1;
  localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam logic [CNT_W-1:0]  LAST_IDX  = CNT_W'(BLK_LEN - 1);
  localparam logic [BANK_W-1:0] LAST_BANK = BANK_W'(NUM_BANKS - 1);

  logic [CNT_W-1:0]  wr_cnt;
  logic [BANK_W-1:0] wr_bank;
  logic              wr_page;
  logic [1:0]        page_full;

  logic [CNT_W-1:0]  rd_cnt;
  logic              rd_page;
  rd_state_t         rd_state;
  rd_state_t         rd_state_nxt;

  logic wr_accept;
  logic wr_drop;
  logic wr_at_end;
  logic wr_blk_end;
  logic wr_page_done;
  logic rd_issue;
  logic rd_done;

  // ---------------------------------------------------------------- write side
  assign wr_accept    = i_wr_vld && !page_full[wr_page];
  assign wr_drop      = i_wr_vld &&  page_full[wr_page];
  assign wr_at_end    = (wr_cnt == LAST_IDX);
  // A block ends on an explicit last or when the index runs out; the latter
  // makes an over-long block spill into the next bank.
  assign wr_blk_end   = wr_accept && (i_wr_last || wr_at_end);
  assign wr_page_done = wr_blk_end && (wr_bank == LAST_BANK);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_cnt     <= '0;
      wr_bank    <= '0;
      wr_page    <= 1'b0;
      o_wr_wen   <= '0;
      o_wr_addr  <= '0;
      o_err_len  <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      o_wr_wen  <= wr_accept ? (NUM_BANKS'(1) << wr_bank) : '0;
      // Short block: last before the final index. Long block: final index
      // without last. Both reduce to last disagreeing with the index.
      o_err_len <= wr_accept && (i_wr_last != wr_at_end);
      if (wr_drop) o_overflow <= 1'b1;
      if (wr_accept) begin
        o_wr_addr <= {wr_page, wr_cnt};
        if (wr_blk_end) begin
          wr_cnt <= '0;
          if (wr_bank == LAST_BANK) begin
            wr_bank <= '0;
            wr_page <= ~wr_page;
          end else begin
            wr_bank <= wr_bank + 1'b1;
          end
        end else begin
          wr_cnt <= wr_cnt + 1'b1;
        end
      end
    end
  end

  // Fill and drain always target different pages (a full page takes no
  // writes), so both updates may land in the same cycle.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      page_full <= 2'b00;
    end else begin
      if (wr_page_done) page_full[wr_page] <= 1'b1;
      if (rd_done)      page_full[rd_page] <= 1'b0;
    end
  end

  // ----------------------------------------------------------------- read side
  assign rd_issue = (rd_state == RD_RUN) && i_rd_ready;
  assign rd_done  = rd_issue && (rd_cnt == LAST_IDX);

  // The full flag is registered, so RD_RUN starts two cycles after the
  // page-completing word: one cycle after its last bank write is visible.
  always_comb begin
    rd_state_nxt = rd_state;
    case (rd_state)
      RD_IDLE: if (page_full[rd_page]) rd_state_nxt = RD_RUN;
      RD_RUN:  if (rd_done)            rd_state_nxt = RD_IDLE;
      default: rd_state_nxt = RD_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rd_state <= RD_IDLE;
      rd_cnt   <= '0;
      rd_page  <= 1'b0;
    end else begin
      rd_state <= rd_state_nxt;
      if (rd_issue) begin
        if (rd_done) begin
          rd_cnt  <= '0;
          rd_page <= ~rd_page;
        end else begin
          rd_cnt  <= rd_cnt + 1'b1;
        end
      end
    end
  end

  assign o_rd_en        = rd_issue;
  assign o_rd_addr      = {rd_page, rd_cnt};
  assign o_page_full    = page_full;
  assign o_dbg_rd_state = rd_state;

  beam_buf_dly #(
    .WIDTH (3),
    .DEPTH (READ_LATENCY)
  ) u_dly (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_d     ({rd_issue, rd_issue && (rd_cnt == '0), rd_done}),
    .o_q     ({o_rd_dvld, o_rd_sop, o_rd_eop})
  );

endmodule

// File: tb/tb_beam_buf_sched.sv
// Directed bench for beam_buf_sched: write words, read addresses and read
// framing are matched against expectation queues filled by each scenario.
module tb_beam_buf_sched;
  import beam_buf_pkg::*;

  localparam int NB  = 4;
  localparam int BL  = 64;
  localparam int AW  = 7;
  localparam int LAT = 3;

  // ------------------------------------------------------------ clock / reset
  logic i_clk = 1'b0;
  logic i_reset;
  always #5 i_clk = ~i_clk;

  logic            i_wr_vld, i_wr_last, i_rd_ready;
  logic [NB-1:0]   o_wr_wen;
  logic [AW-1:0]   o_wr_addr, o_rd_addr;
  logic            o_rd_en, o_rd_dvld, o_rd_sop, o_rd_eop;
  logic [1:0]      o_page_full;
  logic            o_err_len, o_overflow;
  rd_state_t       o_dbg_rd_state;

  beam_buf_sched #(
    .NUM_BANKS (NB), .BLK_LEN (BL), .ADDR_WIDTH (AW), .READ_LATENCY (LAT)
  ) dut (
    .i_clk (i_clk), .i_reset (i_reset),
    .i_wr_vld (i_wr_vld), .i_wr_last (i_wr_last),
    .o_wr_wen (o_wr_wen), .o_wr_addr (o_wr_addr),
    .i_rd_ready (i_rd_ready), .o_rd_en (o_rd_en), .o_rd_addr (o_rd_addr),
    .o_rd_dvld (o_rd_dvld), .o_rd_sop (o_rd_sop), .o_rd_eop (o_rd_eop),
    .o_page_full (o_page_full), .o_err_len (o_err_len),
    .o_overflow (o_overflow), .o_dbg_rd_state (o_dbg_rd_state)
  );

  // -------------------------------------------------------------- scoreboard
  typedef struct packed { int t; logic sop; logic eop; } dv_t;

  logic [11:0]   exp_q[$];     // {err_len, wen, addr} per expected write
  logic [AW-1:0] rd_exp_q[$];  // expected read addresses in order
  dv_t           dv_q[$];      // expected framing, keyed by cycle

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  logic mon_en = 1'b0;
  int wr_seen, rd_seen, dvld_seen, sop_seen, eop_seen, err_seen;
  int last_wr_cyc, first_rd_cyc, last_rd_cyc;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  always @(posedge i_clk) cyc <= cyc + 1;

  always @(negedge i_clk) begin
    logic [11:0]   e;
    logic [AW-1:0] ea;
    dv_t           d;
    if (mon_en) begin
      if (o_wr_wen != '0 || o_err_len) begin
        if (exp_q.size() == 0) check("wr_unexpected", {o_err_len, o_wr_wen, o_wr_addr}, 0);
        else begin
          e = exp_q.pop_front();
          check("wr_word", {o_err_len, o_wr_wen, o_wr_addr}, e);
        end
        wr_seen++;
        err_seen += int'(o_err_len);
        last_wr_cyc = cyc;
      end
      if (o_rd_en) begin
        check("rd_ready_gate", i_rd_ready, 1);
        if (rd_exp_q.size() == 0) check("rd_unexpected", o_rd_addr, 32'hffff);
        else begin
          ea = rd_exp_q.pop_front();
          check("rd_addr", o_rd_addr, ea);
          dv_q.push_back('{t: cyc + LAT, sop: (ea[5:0] == 6'd0), eop: (ea[5:0] == 6'd63)});
        end
        if (rd_seen == 0) first_rd_cyc = cyc;
        last_rd_cyc = cyc;
        rd_seen++;
      end else if (o_dbg_rd_state == RD_RUN && rd_exp_q.size() > 0) begin
        check("rd_hold", o_rd_addr, rd_exp_q[0]);
      end
      if (dv_q.size() > 0 && dv_q[0].t == cyc) begin
        d = dv_q.pop_front();
        check("rd_frame", {o_rd_dvld, o_rd_sop, o_rd_eop}, {1'b1, d.sop, d.eop});
      end else if (o_rd_dvld || o_rd_sop || o_rd_eop) begin
        check("rd_frame_unexpected", {o_rd_dvld, o_rd_sop, o_rd_eop}, 0);
      end
      dvld_seen += int'(o_rd_dvld);
      sop_seen  += int'(o_rd_sop);
      eop_seen  += int'(o_rd_eop);
    end
  end

  // ----------------------------------------------------------- driver tasks
  task automatic clr_stats();
    wr_seen = 0; rd_seen = 0; dvld_seen = 0; sop_seen = 0; eop_seen = 0;
    err_seen = 0; last_wr_cyc = 0; first_rd_cyc = 0; last_rd_cyc = 0;
  endtask

  task automatic check_rst_outputs();
    check("rst_wen", o_wr_wen, 0);
    check("rst_wr_addr", o_wr_addr, 0);
    check("rst_rd_en", o_rd_en, 0);
    check("rst_rd_addr", o_rd_addr, 0);
    check("rst_frame", {o_rd_dvld, o_rd_sop, o_rd_eop}, 0);
    check("rst_page_full", o_page_full, 0);
    check("rst_err_len", o_err_len, 0);
    check("rst_overflow", o_overflow, 0);
    check("rst_state", o_dbg_rd_state, RD_IDLE);
  endtask

  task automatic do_reset();
    @(posedge i_clk); #1;
    mon_en = 1'b0;
    i_reset = 1'b1;
    @(posedge i_clk); #1;
    i_reset = 1'b0;
    exp_q.delete(); rd_exp_q.delete(); dv_q.delete();
    @(negedge i_clk);
    check_rst_outputs();
    clr_stats();
    mon_en = 1'b1;
  endtask

  task automatic exp_block(input int bank, input int page, input int nwords, input int err_at);
    logic [3:0] wen;
    logic       err;
    wen = 4'b0001 << bank;
    for (int w = 0; w < nwords; w++) begin
      err = (w == err_at);
      exp_q.push_back({err, wen, page[0], w[5:0]});
    end
  endtask

  task automatic exp_reads(input int page);
    for (int i = 0; i < BL; i++) rd_exp_q.push_back(AW'(page * BL + i));
  endtask

  task automatic send_block(input int nwords, input int last_at);
    for (int w = 0; w < nwords; w++) begin
      @(posedge i_clk); #1;
      i_wr_vld  = 1'b1;
      i_wr_last = (w == last_at);
    end
  endtask

  task automatic wr_idle();
    @(posedge i_clk); #1;
    i_wr_vld  = 1'b0;
    i_wr_last = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 3000; i++) begin
      @(negedge i_clk);
      if (exp_q.size() == 0 && rd_exp_q.size() == 0 && dv_q.size() == 0) break;
    end
    check("drain", exp_q.size() + rd_exp_q.size() + dv_q.size(), 0);
    repeat (5) @(negedge i_clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // --------------------------------------------------------------- scenarios
  initial begin
    i_reset = 1'b1; i_wr_vld = 1'b0; i_wr_last = 1'b0; i_rd_ready = 1'b0;
    clr_stats();
    repeat (2) @(posedge i_clk); #1;
    i_reset = 1'b0;
    @(negedge i_clk);
    check_rst_outputs();
    mon_en = 1'b1;

    // Single page fill, full-rate sweep.
    i_rd_ready = 1'b1;
    for (int b = 0; b < NB; b++) exp_block(b, 0, BL, -1);
    exp_reads(0);
    for (int b = 0; b < NB; b++) send_block(BL, BL - 1);
    wr_idle();
    @(negedge i_clk);
    check("fill_page_full", o_page_full, 2'b01);
    wait_idle();
    check("fill_rd_start", first_rd_cyc - last_wr_cyc, 1);
    check("fill_full_rate", last_rd_cyc - first_rd_cyc, BL - 1);
    check("fill_dvld_cnt", dvld_seen, BL);
    check("fill_sop_eop", {sop_seen[7:0], eop_seen[7:0]}, 16'h0101);
    check("fill_page_empty", o_page_full, 2'b00);

    // Ping-pong: page 1 is written while page 0 drains.
    do_reset();
    i_rd_ready = 1'b1;
    for (int b = 0; b < 2 * NB; b++) exp_block(b % NB, b / NB, BL, -1);
    exp_reads(0);
    exp_reads(1);
    for (int b = 0; b < 2 * NB; b++) send_block(BL, BL - 1);
    wr_idle();
    @(negedge i_clk);
    check("pp_page0_read_during_fill", rd_seen, BL);
    wait_idle();
    check("pp_reads", rd_seen, 2 * BL);
    check("pp_overflow", o_overflow, 0);
    check("pp_page_empty", o_page_full, 2'b00);

    // Overflow: both pages fill with no reads, the ninth block is dropped.
    do_reset();
    i_rd_ready = 1'b0;
    for (int b = 0; b < 2 * NB; b++) exp_block(b % NB, b / NB, BL, -1);
    exp_reads(0);
    exp_reads(1);
    for (int b = 0; b < 2 * NB; b++) send_block(BL, BL - 1);
    wr_idle();
    @(negedge i_clk);
    check("ovf_both_full", o_page_full, 2'b11);
    check("ovf_not_yet", o_overflow, 0);
    send_block(BL, BL - 1);
    wr_idle();
    @(negedge i_clk);
    check("ovf_set", o_overflow, 1);
    check("ovf_dropped", wr_seen, 2 * NB * BL);
    @(posedge i_clk); #1;
    i_rd_ready = 1'b1;
    wait_idle();
    check("ovf_sticky", o_overflow, 1);
    check("ovf_drained", o_page_full, 2'b00);

    // Length errors: short block then an over-long block.
    do_reset();
    i_rd_ready = 1'b1;
    exp_block(0, 0, 41, 40);
    exp_block(1, 0, BL, BL - 1);
    exp_block(2, 0, 6, -1);
    send_block(41, 40);
    send_block(70, -1);
    wr_idle();
    wait_idle();
    check("len_err_pulses", err_seen, 2);
    check("len_words", wr_seen, 41 + 70);
    check("len_no_read", rd_seen, 0);

    // Stalls: ready toggles every cycle during the sweep.
    do_reset();
    i_rd_ready = 1'b0;
    for (int b = 0; b < NB; b++) exp_block(b, 0, BL, -1);
    exp_reads(0);
    for (int b = 0; b < NB; b++) send_block(BL, BL - 1);
    wr_idle();
    repeat (3) @(negedge i_clk);
    for (int i = 0; i < 400 && (rd_exp_q.size() != 0 || dv_q.size() != 0); i++) begin
      @(posedge i_clk); #1;
      i_rd_ready = ~i_rd_ready;
    end
    i_rd_ready = 1'b1;
    wait_idle();
    check("stall_dvld_cnt", dvld_seen, BL);
    check("stall_span", last_rd_cyc - first_rd_cyc, 2 * (BL - 1));

    // Reset mid-sweep, then a clean refill.
    do_reset();
    i_rd_ready = 1'b1;
    for (int b = 0; b < NB; b++) exp_block(b, 0, BL, -1);
    exp_reads(0);
    for (int b = 0; b < NB; b++) send_block(BL, BL - 1);
    wr_idle();
    for (int i = 0; i < 500; i++) begin
      @(negedge i_clk);
      if (rd_seen >= 20) break;
    end
    check("mid_reads_reached", rd_seen, 20);
    do_reset();
    repeat (10) @(negedge i_clk);
    check("mid_no_stray_frame", dvld_seen + sop_seen + eop_seen, 0);
    for (int b = 0; b < NB; b++) exp_block(b, 0, BL, -1);
    exp_reads(0);
    for (int b = 0; b < NB; b++) send_block(BL, BL - 1);
    wr_idle();
    wait_idle();
    check("mid_refill_dvld", dvld_seen, BL);
    check("mid_refill_sop_eop", {sop_seen[7:0], eop_seen[7:0]}, 16'h0101);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
